opb_register_simulink2ppc: RTL and testbench

OPB slave that lets the PowerPC read a 32-bit value produced by Simulink user logic. This is the reverse path of the PPC-to-Simulink software register.
- User logic presents a word with a valid strobe. The block latches it, honouring a software freeze control.
- The block flags new data and returns the latched word on OPB reads with a one-cycle registered acknowledge.
- Sits on the OPB bus beside the other software registers, one instance per readable register.

---
 rtl/opb_sw_reg_pkg.sv | 19 +
 rtl/opb_register_simulink2ppc_if.sv | 30 +++
 rtl/opb_slave_ack_fsm.sv | 67 ++++++
 rtl/opb_register_simulink2ppc.sv | 147 ++++++++++++++
 tb/tb_opb_register_simulink2ppc.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/opb_sw_reg_pkg.sv
// Shared definitions for the OPB software-register slaves.
//   - Register offsets inside the decoded window (word aligned).
//   - CTRL register bit positions (little-endian word numbering).
//   - Acknowledge FSM state type.
package opb_sw_reg_pkg;

  localparam logic [31:0] OFF_DATA = 32'h0000_0000;
  localparam logic [31:0] OFF_CTRL = 32'h0000_0004;
  localparam logic [31:0] OFF_CNT  = 32'h0000_0008;

  localparam int unsigned CTRL_NEW_BIT    = 31;
  localparam int unsigned CTRL_FREEZE_BIT = 0;

  typedef enum logic {
    StIdle,
    StAck
  } ack_state_e;

endpackage

// File: rtl/opb_register_simulink2ppc_if.sv
// OPB bus bundle between the bus (master modport) and one software-register slave (slave modport).
// Signal names and big-endian [0:N] ranges follow the OPB convention: bit 0 is the MSB.
//   OPB_ABus/OPB_BE/OPB_DBus/OPB_RNW/OPB_select/OPB_seqAddr : bus -> slave
//   Sl_DBus/Sl_errAck/Sl_retry/Sl_toutSup/Sl_xferAck         : slave -> bus
interface opb_register_simulink2ppc_if;

  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;

  logic [0:31] Sl_DBus;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;
  logic        Sl_xferAck;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
  );

endinterface

// File: rtl/opb_slave_ack_fsm.sv
// Address decode and one-cycle acknowledge sequencer for an OPB software-register slave.
// Ports:
//   clk_i      - OPB clock
//   rst_i      - synchronous active-high reset
//   select_i   - OPB_select
//   addr_i     - OPB address, numeric value (MSB at bit 31)
//   start_o    - a transfer is accepted on this edge (IDLE and hit)
//   offset_o   - word-aligned offset of addr_i from C_BASEADDR
//   xfer_ack_o - high for exactly the cycle after an accepted transfer
module opb_slave_ack_fsm
  import opb_sw_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR = 32'h0000_00FF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        select_i,
  input  logic [31:0] addr_i,
  output logic        start_o,
  output logic [31:0] offset_o,
  output logic        xfer_ack_o
);

  localparam logic [31:0] Span = C_HIGHADDR - C_BASEADDR;

  ack_state_e state_d, state_q;

  // A 33-bit subtraction gives both the offset and "addr below base" (the borrow),
  // avoiding a compare against a base that may be zero.
  logic [32:0] diff;
  logic        hit;

  assign diff     = {1'b0, addr_i} - {1'b0, C_BASEADDR};
  assign hit      = select_i && !diff[32] && (diff[31:0] <= Span);
  assign offset_o = {diff[31:2], 2'b00};

  logic unused_diff;
  assign unused_diff = ^diff[1:0];

  always_comb begin
    state_d = state_q;
    start_o = 1'b0;
    case (state_q)
      StIdle: begin
        if (hit) begin
          state_d = StAck;
          start_o = 1'b1;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
    endcase
  end

  assign xfer_ack_o = (state_q == StAck);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/opb_register_simulink2ppc.sv
// OPB slave that lets the processor read a 32-bit word produced by user logic.
// Register window (offsets from C_BASEADDR, ABus[30:31] ignored):
//   0x0 DATA  read-only latched user word (writes acked and dropped)
//   0x4 CTRL  bit31 new_flag (RO), bit0 freeze (RW, written only when BE[3]=1)
//   0x8 CNT   accepted-capture count, write clears (only with SIMULINK2PPC_CAPTURE_COUNT_EN)
//   others    acked, read 0
// Ports:
//   OPB_Clk, OPB_Rst            - clock, synchronous active-high reset
//   opb                         - OPB slave bundle (see opb_register_simulink2ppc_if)
//   user_data_in/user_data_valid - user word and its capture strobe (OPB_Clk domain)
// Optional macro: SIMULINK2PPC_CAPTURE_COUNT_EN enables the capture counter at 0x8.
module opb_register_simulink2ppc
  import opb_sw_reg_pkg::*;
#(
  parameter logic [31:0]  C_BASEADDR   = 32'h0000_0000,
  parameter logic [31:0]  C_HIGHADDR   = 32'h0000_00FF,
  parameter int unsigned  C_OPB_AWIDTH = 32,
  parameter int unsigned  C_OPB_DWIDTH = 32,
  parameter logic [63:0]  C_FAMILY     = "virtex5"
) (
  input  logic                              OPB_Clk,
  input  logic                              OPB_Rst,
  opb_register_simulink2ppc_if.slave        opb,
  input  logic [31:0]                       user_data_in,
  input  logic                              user_data_valid
);

  logic [31:0] abus;
  logic [31:0] wdata;
  logic        start;
  logic [31:0] offset;
  logic        xfer_ack;

  // [0:31] -> [31:0] preserves numeric value, so word bit i == DBus[31-i].
  assign abus  = opb.OPB_ABus;
  assign wdata = opb.OPB_DBus;

  opb_slave_ack_fsm #(
    .C_BASEADDR (C_BASEADDR),
    .C_HIGHADDR (C_HIGHADDR)
  ) u_ack_fsm (
    .clk_i      (OPB_Clk),
    .rst_i      (OPB_Rst),
    .select_i   (opb.OPB_select),
    .addr_i     (abus),
    .start_o    (start),
    .offset_o   (offset),
    .xfer_ack_o (xfer_ack)
  );

  logic rd, wr, capture;
  assign rd      = start && opb.OPB_RNW;
  assign wr      = start && !opb.OPB_RNW;
  assign capture = user_data_valid && !freeze_q;

  logic [31:0] data_d, data_q;
  logic        new_flag_d, new_flag_q;
  logic        freeze_d, freeze_q;
  logic [31:0] sl_dbus_d, sl_dbus_q;
  logic [31:0] rdata;

`ifdef SIMULINK2PPC_CAPTURE_COUNT_EN
  logic [31:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (wr && offset == OFF_CNT) begin
      // A clear that coincides with a capture counts that capture.
      cnt_d = capture ? 32'd1 : 32'd0;
    end else if (capture) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  always_comb begin
    rdata = '0;
    if (offset == OFF_DATA) begin
      rdata = data_q;
    end else if (offset == OFF_CTRL) begin
      rdata[CTRL_NEW_BIT]    = new_flag_q;
      rdata[CTRL_FREEZE_BIT] = freeze_q;
    end
`ifdef SIMULINK2PPC_CAPTURE_COUNT_EN
    else if (offset == OFF_CNT) begin
      rdata = cnt_q;
    end
`endif
  end

  always_comb begin
    data_d     = data_q;
    new_flag_d = new_flag_q;
    freeze_d   = freeze_q;
    // Read data is loaded only on the accepting edge, so it is nonzero only in the ack cycle.
    sl_dbus_d  = rd ? rdata : '0;

    if (capture) begin
      data_d = user_data_in;
    end

    // Set wins over a coincident DATA-read clear.
    if (capture) begin
      new_flag_d = 1'b1;
    end else if (rd && offset == OFF_DATA) begin
      new_flag_d = 1'b0;
    end

    if (wr && offset == OFF_CTRL && opb.OPB_BE[3]) begin
      freeze_d = wdata[CTRL_FREEZE_BIT];
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      data_q     <= '0;
      new_flag_q <= 1'b0;
      freeze_q   <= 1'b0;
      sl_dbus_q  <= '0;
    end else begin
      data_q     <= data_d;
      new_flag_q <= new_flag_d;
      freeze_q   <= freeze_d;
      sl_dbus_q  <= sl_dbus_d;
    end
  end

  assign opb.Sl_DBus    = sl_dbus_q;
  assign opb.Sl_xferAck = xfer_ack;
  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;

  // Bus fields this register never looks at, plus pass-through configuration.
  logic unused_opb;
  assign unused_opb = ^{opb.OPB_seqAddr, opb.OPB_BE[0:2], wdata[31:1], C_FAMILY,
                        C_OPB_AWIDTH, C_OPB_DWIDTH};

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
module tb_opb_register_simulink2ppc;

  localparam logic [31:0] Base = 32'h0000_0100;
  localparam logic [31:0] High = 32'h0000_01FF;

  logic        clk;
  logic        rst;
  logic [31:0] user_data_in;
  logic        user_data_valid;

  opb_register_simulink2ppc_if bus ();

  opb_register_simulink2ppc #(
    .C_BASEADDR   (Base),
    .C_HIGHADDR   (High),
    .C_OPB_AWIDTH (32),
    .C_OPB_DWIDTH (32),
    .C_FAMILY     ("virtex5")
  ) dut (
    .OPB_Clk         (clk),
    .OPB_Rst         (rst),
    .opb             (bus),
    .user_data_in    (user_data_in),
    .user_data_valid (user_data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cap;
    logic [31:0] cap_data;
    logic        sel;
    logic        rnw;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

`ifdef SIMULINK2PPC_CAPTURE_COUNT_EN
  localparam logic [31:0] CntAfterTable = 32'd4;
`else
  localparam logic [31:0] CntAfterTable = 32'd0;
`endif

  function automatic vec_t mk_cap(input logic [31:0] d);
    vec_t v = '{1'b1, d, 1'b0, 1'b1, 32'h0, 4'hF, 32'h0, 32'h0};
    return v;
  endfunction

  function automatic vec_t mk_rd(input logic [31:0] off, input logic [31:0] e);
    vec_t v = '{1'b0, 32'h0, 1'b1, 1'b1, Base + off, 4'hF, 32'h0, e};
    return v;
  endfunction

  function automatic vec_t mk_rdcap(input logic [31:0] off, input logic [31:0] e,
                                    input logic [31:0] d);
    vec_t v = '{1'b1, d, 1'b1, 1'b1, Base + off, 4'hF, 32'h0, e};
    return v;
  endfunction

  function automatic vec_t mk_wr(input logic [31:0] off, input logic [3:0] be,
                                 input logic [31:0] d);
    vec_t v = '{1'b0, 32'h0, 1'b1, 1'b0, Base + off, be, d, 32'h0};
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %08h, expected %08h", name, idx, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    user_data_valid = v.cap;
    user_data_in    = v.cap_data;
    bus.OPB_select  = v.sel;
    bus.OPB_RNW     = v.rnw;
    bus.OPB_ABus    = v.addr;
    bus.OPB_BE      = v.be;
    bus.OPB_DBus    = v.wdata;
    @(posedge clk);
    #1;
    user_data_valid = 1'b0;
    bus.OPB_select  = 1'b0;
    if (v.sel) begin
      check("ack", idx, {31'b0, bus.Sl_xferAck}, 32'd1);
      if (v.rnw) check("rdata", idx, bus.Sl_DBus, v.exp);
      else       check("wr_dbus", idx, bus.Sl_DBus, 32'h0);
      @(posedge clk);
      #1;
      check("ack_drop", idx, {31'b0, bus.Sl_xferAck}, 32'd0);
      check("dbus_idle", idx, bus.Sl_DBus, 32'h0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 0, {31'b0, bus.Sl_xferAck}, 32'd0);
    check("rst_dbus", 0, bus.Sl_DBus, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    user_data_in    = '0;
    user_data_valid = 1'b0;
    bus.OPB_ABus    = '0;
    bus.OPB_BE      = '0;
    bus.OPB_DBus    = '0;
    bus.OPB_RNW     = 1'b1;
    bus.OPB_select  = 1'b0;
    bus.OPB_seqAddr = 1'b0;

    vecs.push_back(mk_rd(32'h0, 32'h0));                      // reset DATA
    vecs.push_back(mk_rd(32'h4, 32'h0));                      // reset CTRL
    vecs.push_back(mk_cap(32'hDEAD_BEEF));
    vecs.push_back(mk_rd(32'h0, 32'hDEAD_BEEF));
    vecs.push_back(mk_rd(32'h4, 32'h0));                      // flag cleared by DATA read
    vecs.push_back(mk_cap(32'h1234_5678));
    vecs.push_back(mk_rd(32'h4, 32'h8000_0000));
    vecs.push_back(mk_rd(32'h0, 32'h1234_5678));
    vecs.push_back(mk_rd(32'h4, 32'h0));
    vecs.push_back(mk_wr(32'h4, 4'b0001, 32'h0000_0001));     // freeze
    vecs.push_back(mk_cap(32'hAAAA_AAAA));                    // dropped
    vecs.push_back(mk_rd(32'h0, 32'h1234_5678));
    vecs.push_back(mk_rd(32'h4, 32'h0000_0001));
    vecs.push_back(mk_wr(32'h4, 4'b1110, 32'h0000_0000));     // BE[3]=0: no effect
    vecs.push_back(mk_rd(32'h4, 32'h0000_0001));
    vecs.push_back(mk_rdcap(32'h0, 32'h1234_5678, 32'h5555_5555));
    vecs.push_back(mk_rd(32'h4, 32'h0000_0001));
    vecs.push_back(mk_wr(32'h4, 4'b0001, 32'h0000_0000));     // unfreeze
    vecs.push_back(mk_cap(32'h0000_0001));
    vecs.push_back(mk_rdcap(32'h0, 32'h0000_0001, 32'h0000_0002)); // old data returned
    vecs.push_back(mk_rd(32'h4, 32'h8000_0000));              // set wins
    vecs.push_back(mk_rd(32'h0, 32'h0000_0002));
    vecs.push_back(mk_rd(32'h10, 32'h0));                     // unmapped
    vecs.push_back(mk_wr(32'h0, 4'hF, 32'hFFFF_FFFF));        // DATA write dropped
    vecs.push_back(mk_rd(32'h0, 32'h0000_0002));
    vecs.push_back(mk_rd(32'h7, 32'h0));                      // low addr bits ignored -> CTRL
    vecs.push_back(mk_rd(High - Base, 32'h0));                // last byte of window
    vecs.push_back(mk_rd(32'h8, CntAfterTable));
    vecs.push_back(mk_wr(32'h8, 4'hF, 32'h0));
    vecs.push_back(mk_rd(32'h8, 32'h0));
    vecs.push_back(mk_rd(32'h2, 32'h0000_0002));              // -> DATA

    do_reset();

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], i);
    end

    // Select held for 4 cycles: acks on cycles 1 and 3 only.
    @(negedge clk);
    bus.OPB_select = 1'b1;
    bus.OPB_RNW    = 1'b1;
    bus.OPB_ABus   = Base + OFFSET_DATA_TB();
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      check("held_ack", c, {31'b0, bus.Sl_xferAck}, (c == 1 || c == 3) ? 32'd1 : 32'd0);
      check("held_dbus", c, bus.Sl_DBus, (c == 1 || c == 3) ? 32'h2 : 32'h0);
    end
    bus.OPB_select = 1'b0;

    // Outside the window on both sides: never acked.
    @(negedge clk);
    bus.OPB_select = 1'b1;
    bus.OPB_ABus   = High + 32'd4;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("oow_hi_ack", c, {31'b0, bus.Sl_xferAck}, 32'd0);
      check("oow_hi_dbus", c, bus.Sl_DBus, 32'h0);
    end
    bus.OPB_ABus = Base - 32'd4;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      check("oow_lo_ack", c, {31'b0, bus.Sl_xferAck}, 32'd0);
    end
    bus.OPB_select = 1'b0;

    // Reset on the edge that would accept a read: no ack, state cleared.
    @(negedge clk);
    bus.OPB_select = 1'b1;
    bus.OPB_ABus   = Base;
    rst            = 1'b1;
    @(posedge clk);
    #1;
    check("rst_xfer_ack", 0, {31'b0, bus.Sl_xferAck}, 32'd0);
    check("rst_xfer_dbus", 0, bus.Sl_DBus, 32'h0);
    bus.OPB_select = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_xfer_ack2", 1, {31'b0, bus.Sl_xferAck}, 32'd0);
    run_vec(mk_rd(32'h0, 32'h0), 100);
    run_vec(mk_rd(32'h4, 32'h0), 101);

`ifdef SIMULINK2PPC_CAPTURE_COUNT_EN
    for (int k = 0; k < 5; k++) begin
      run_vec(mk_cap(32'h100 + k), 200 + k);
    end
    run_vec(mk_rd(32'h8, 32'd5), 205);
    run_vec(mk_wr(32'h8, 4'hF, 32'h0), 206);
    run_vec(mk_rd(32'h8, 32'd0), 207);
    begin
      vec_t wc;
      wc     = mk_wr(32'h8, 4'b0001, 32'h0);
      wc.cap = 1'b1;
      wc.cap_data = 32'h0000_0009;
      run_vec(wc, 208);
    end
    run_vec(mk_rd(32'h8, 32'd1), 209);
    run_vec(mk_rd(32'h0, 32'h9), 210);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  function automatic logic [31:0] OFFSET_DATA_TB();
    return 32'h0;
  endfunction

endmodule
